// File: rtl/mips_defs.sv
// Shared MIPS encoding constants: opcodes, funct codes, field positions and fetch defaults.
package mips_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

  // Primary opcodes
  localparam logic [5:0] R_TYPE = 6'h00;
  localparam logic [5:0] J      = 6'h02;
  localparam logic [5:0] JAL    = 6'h03;
  localparam logic [5:0] BEQ    = 6'h04;
  localparam logic [5:0] ADDI   = 6'h08;
  localparam logic [5:0] ADDIU  = 6'h09;
  localparam logic [5:0] ORI    = 6'h0D;
  localparam logic [5:0] LUI    = 6'h0F;
  localparam logic [5:0] LW     = 6'h23;
  localparam logic [5:0] SW     = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] JR   = 6'h08;
  localparam logic [5:0] ADDU = 6'h21;
  localparam logic [5:0] SUB  = 6'h22;

  // Instruction field bit positions
  localparam int unsigned OPCODE_HI = 31;
  localparam int unsigned OPCODE_LO = 26;
  localparam int unsigned RS_HI     = 25;
  localparam int unsigned RS_LO     = 21;
  localparam int unsigned RT_HI     = 20;
  localparam int unsigned RT_LO     = 16;
  localparam int unsigned RD_HI     = 15;
  localparam int unsigned RD_LO     = 11;
  localparam int unsigned SHAMT_HI  = 10;
  localparam int unsigned SHAMT_LO  = 6;
  localparam int unsigned FUNCT_HI  = 5;
  localparam int unsigned FUNCT_LO  = 0;
  localparam int unsigned IMM_HI    = 15;
  localparam int unsigned IMM_LO    = 0;
  localparam int unsigned JIDX_HI   = 25;
  localparam int unsigned JIDX_LO   = 0;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and IF/ID decode fields.
interface fetch_stage_if;

  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [4:0]  id_shamt;
  logic [5:0]  id_funct;
  logic [15:0] id_imm16;
  logic [31:0] id_jtarget;

  // Fetch stage side
  modport master (
    input  stall, flush, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, pc, id_valid, id_pc, id_pc_plus4, id_instr,
           id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct, id_imm16, id_jtarget
  );

  // Hazard unit / memory / decode side
  modport slave (
    output stall, flush, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, pc, id_valid, id_pc, id_pc_plus4, id_instr,
           id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct, id_imm16, id_jtarget
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register (valid, pc, instr) with reset > bubble > stall > load priority.
module if_id_reg #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        bubble_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;

  // A bubble clears valid/instr but leaves pc untouched.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0000_0000;
      instr_q <= NOP_WORD;
    end else if (bubble_i) begin
      valid_q <= 1'b0;
      instr_q <= NOP_WORD;
    end else if (!stall_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, redirect/stall/flush handling and IF/ID field split.
module fetch_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master bus
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic        bubble;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;
  assign bubble   = bus.redirect_valid | bus.flush;

  // Redirect beats stall; a flush alone still lets the PC advance unless stalled.
  always_comb begin
    pc_d = pc_plus4;
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc & ~32'h0000_0003;
    end else if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  if_id_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_if_id_reg (
    .clk_i   (clk),
    .reset_i (reset),
    .bubble_i(bubble),
    .stall_i (bus.stall),
    .pc_i    (pc_q),
    .instr_i (bus.imem_rdata),
    .valid_o (bus.id_valid),
    .pc_o    (id_pc),
    .instr_o (id_instr)
  );

  assign id_pc_plus4 = id_pc + 32'd4;

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.id_pc       = id_pc;
  assign bus.id_instr    = id_instr;
  assign bus.id_pc_plus4 = id_pc_plus4;
  assign bus.id_opcode   = id_instr[OPCODE_HI:OPCODE_LO];
  assign bus.id_rs       = id_instr[RS_HI:RS_LO];
  assign bus.id_rt       = id_instr[RT_HI:RT_LO];
  assign bus.id_rd       = id_instr[RD_HI:RD_LO];
  assign bus.id_shamt    = id_instr[SHAMT_HI:SHAMT_LO];
  assign bus.id_funct    = id_instr[FUNCT_HI:FUNCT_LO];
  assign bus.id_imm16    = id_instr[IMM_HI:IMM_LO];
  assign bus.id_jtarget  = {id_pc_plus4[31:28], id_instr[JIDX_HI:JIDX_LO], 2'b00};

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table plus random stimulus against a behavioural model.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_idpc, m_instr;
  logic        m_valid;

  typedef struct {
    logic        rst, st, fl, rv;
    logic [31:0] rpc, rd;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_idpc, e_instr;
    logic        chk_jt;
    logic [31:0] e_jt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic rst, st, fl, rv, input logic [31:0] rpc, rd,
                              input logic [31:0] e_pc, input logic e_valid,
                              input logic [31:0] e_idpc, e_instr,
                              input logic chk_jt, input logic [31:0] e_jt);
    vec_t v;
    v.rst = rst; v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc; v.rd = rd;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_idpc = e_idpc; v.e_instr = e_instr;
    v.chk_jt = chk_jt; v.e_jt = e_jt;
    vecs.push_back(v);
  endfunction

  // Compare every output against the model using arithmetic field extraction.
  task automatic compare_model();
    logic [31:0] plus4;
    plus4 = m_idpc + 32'd4;
    chk("pc", bus.pc, m_pc);
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("id_valid", {31'd0, bus.id_valid}, {31'd0, m_valid});
    chk("id_pc", bus.id_pc, m_idpc);
    chk("id_instr", bus.id_instr, m_instr);
    chk("id_pc_plus4", bus.id_pc_plus4, plus4);
    chk("id_opcode", {26'd0, bus.id_opcode}, m_instr / 32'd67108864);
    chk("id_rs", {27'd0, bus.id_rs}, (m_instr / 32'd2097152) % 32'd32);
    chk("id_rt", {27'd0, bus.id_rt}, (m_instr / 32'd65536) % 32'd32);
    chk("id_rd", {27'd0, bus.id_rd}, (m_instr / 32'd2048) % 32'd32);
    chk("id_shamt", {27'd0, bus.id_shamt}, (m_instr / 32'd64) % 32'd32);
    chk("id_funct", {26'd0, bus.id_funct}, m_instr % 32'd64);
    chk("id_imm16", {16'd0, bus.id_imm16}, m_instr % 32'd65536);
    chk("id_jtarget", bus.id_jtarget,
        (plus4 & 32'hF000_0000) + ((m_instr % 32'd67108864) * 32'd4));
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1ns later.
  task automatic step(input logic rst, st, fl, rv, input logic [31:0] rpc, rd);
    @(negedge clk);
    reset              = rst;
    bus.stall          = st;
    bus.flush          = fl;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.imem_rdata     = rd;
    @(posedge clk);
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_idpc = 32'h0;
    end else if (rv) begin
      m_pc = rpc - (rpc % 32'd4); m_valid = 1'b0; m_instr = 32'h0;
    end else if (fl) begin
      m_valid = 1'b0; m_instr = 32'h0;
      if (!st) m_pc = m_pc + 32'd4;
    end else if (!st) begin
      m_instr = rd; m_idpc = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    end
    #1;
    compare_model();
  endtask

  initial begin
    reset = 1'b1;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0; bus.imem_rdata = 32'h0;
    m_pc = 32'h0; m_valid = 1'b0; m_instr = 32'h0; m_idpc = 32'h0;

    // rst st fl rv rpc rd | pc valid idpc instr | jt?
    add(1,0,0,0, 32'h0,         32'hDEAD_BEEF, 32'h0,         0, 32'h0,         32'h0,         1, 32'h0);
    add(0,0,0,0, 32'h0,         32'h2008_0005, 32'h4,         1, 32'h0,         32'h2008_0005, 0, 32'h0);
    add(0,0,0,0, 32'h0,         32'h1111_0001, 32'h8,         1, 32'h4,         32'h1111_0001, 0, 32'h0);
    add(0,0,0,0, 32'h0,         32'h2222_0002, 32'hC,         1, 32'h8,         32'h2222_0002, 0, 32'h0);
    add(0,1,0,0, 32'h0,         32'h3333_0003, 32'hC,         1, 32'h8,         32'h2222_0002, 0, 32'h0);
    add(0,1,0,0, 32'h0,         32'h3333_0003, 32'hC,         1, 32'h8,         32'h2222_0002, 0, 32'h0);
    add(0,0,0,0, 32'h0,         32'h3333_0003, 32'h10,        1, 32'hC,         32'h3333_0003, 0, 32'h0);
    add(0,1,0,1, 32'h43,        32'h4444_0004, 32'h40,        0, 32'hC,         32'h0,         0, 32'h0);
    add(0,0,0,0, 32'h0,         32'h5555_0005, 32'h44,        1, 32'h40,        32'h5555_0005, 0, 32'h0);
    add(0,0,0,1, 32'h1C,        32'h0,         32'h1C,        0, 32'h40,        32'h0,         0, 32'h0);
    add(0,0,0,0, 32'h0,         32'h6666_0006, 32'h20,        1, 32'h1C,        32'h6666_0006, 0, 32'h0);
    add(0,0,1,0, 32'h0,         32'h7777_0007, 32'h24,        0, 32'h1C,        32'h0,         0, 32'h0);
    add(0,0,0,1, 32'h1C,        32'h0,         32'h1C,        0, 32'h1C,        32'h0,         0, 32'h0);
    add(0,0,0,0, 32'h0,         32'h6666_0006, 32'h20,        1, 32'h1C,        32'h6666_0006, 0, 32'h0);
    add(0,1,1,0, 32'h0,         32'h7777_0007, 32'h20,        0, 32'h1C,        32'h0,         0, 32'h0);
    add(0,0,0,1, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFC, 0, 32'h1C,        32'h0,         0, 32'h0);
    add(0,0,0,0, 32'h0,         32'h0800_0010, 32'h0,         1, 32'hFFFF_FFFC, 32'h0800_0010, 1, 32'h40);
    add(0,0,0,1, 32'h0040_0000, 32'h0,         32'h0040_0000, 0, 32'hFFFF_FFFC, 32'h0,         0, 32'h0);
    add(0,0,0,0, 32'h0,         32'h0800_0010, 32'h0040_0004, 1, 32'h0040_0000, 32'h0800_0010, 1, 32'h40);
    add(0,0,0,1, 32'h7C,        32'h0,         32'h7C,        0, 32'h0040_0000, 32'h0,         0, 32'h0);
    add(0,0,0,0, 32'h0,         32'h8888_0008, 32'h80,        1, 32'h7C,        32'h8888_0008, 0, 32'h0);
    add(0,1,0,0, 32'h0,         32'h9999_0009, 32'h80,        1, 32'h7C,        32'h8888_0008, 0, 32'h0);
    add(1,1,0,0, 32'h0,         32'h9999_0009, 32'h0,         0, 32'h0,         32'h0,         1, 32'h0);
    add(0,0,0,0, 32'h0,         32'h2008_0005, 32'h4,         1, 32'h0,         32'h2008_0005, 0, 32'h0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].fl, vecs[i].rv, vecs[i].rpc, vecs[i].rd);
      chk($sformatf("vec%0d_pc", i), bus.pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_valid", i), {31'd0, bus.id_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d_idpc", i), bus.id_pc, vecs[i].e_idpc);
      chk($sformatf("vec%0d_instr", i), bus.id_instr, vecs[i].e_instr);
      if (vecs[i].chk_jt) chk($sformatf("vec%0d_jtarget", i), bus.id_jtarget, vecs[i].e_jt);
    end

    // Hand-checked decode of addi $t0,$zero,5 after the final vector.
    chk("addi_opcode", {26'd0, bus.id_opcode}, 32'h08);
    chk("addi_rt", {27'd0, bus.id_rt}, 32'd8);
    chk("addi_imm16", {16'd0, bus.id_imm16}, 32'h5);
    chk("addi_plus4", bus.id_pc_plus4, 32'h4);

    // Random traffic; occasional redirects near the top of memory exercise wrap.
    for (int n = 0; n < 3000; n++) begin
      logic        r_rst, r_st, r_fl, r_rv;
      logic [31:0] r_rpc;
      r_rst = ($urandom_range(63) == 0);
      r_st  = ($urandom_range(3) == 0);
      r_fl  = ($urandom_range(7) == 0);
      r_rv  = ($urandom_range(7) == 0);
      r_rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                       : $urandom;
      step(r_rst, r_st, r_fl, r_rv, r_rpc, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the MIPS core.
- Holds the PC, drives the instruction-memory address, and latches the returned word.
- Splits the latched word into decode fields. id_imm16 feeds the sign-extension unit directly; the other fields feed the control unit and register file.
- Supports stall, flush and taken-branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned).
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard stall: hold PC and IF/ID contents
- flush  input  1  kill the instruction entering IF/ID (insert bubble)
- redirect_valid  input  1  taken branch/jump/jr: load new PC
- redirect_pc  input  32  target address; bits [1:0] ignored
- imem_addr  output  32  instruction-memory address (= current PC, combinational from the PC register)
- imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle
- pc  output  32  current fetch PC
- id_valid  output  1  IF/ID holds a real instruction
- id_pc  output  32  PC of the instruction in IF/ID
- id_pc_plus4  output  32  id_pc + 4, modulo 2^32
- id_instr  output  32  latched instruction word
- id_opcode  output  6  id_instr[31:26]
- id_rs  output  5  id_instr[25:21]
- id_rt  output  5  id_instr[20:16]
- id_rd  output  5  id_instr[15:11]
- id_shamt  output  5  id_instr[10:6]
- id_funct  output  6  id_instr[5:0]
- id_imm16  output  16  id_instr[15:0], to the sign-extension unit
- id_jtarget  output  32  {id_pc_plus4[31:28], id_instr[25:0], 2'b00}

Behaviour:
- Reset:
  - pc=RESET_PC, id_valid=0, id_instr=NOP_WORD, id_pc=0.
  - All field outputs are derived from these values: all zero; id_pc_plus4=4; id_jtarget=0.
  - Reset overrides every other input.
- Per rising edge, first match wins:
  1. reset: as above.
  2. redirect_valid=1:
     - pc <= {redirect_pc[31:2],2'b00}.
     - IF/ID <= bubble: id_valid=0, id_instr=NOP_WORD; id_pc keeps its old value.
     - Applies regardless of stall and flush.
  3. flush=1:
     - IF/ID <= bubble.
     - pc <= stall ? pc : pc+4.
  4. stall=1: pc, id_valid, id_pc and id_instr all hold.
  5. Otherwise:
     - id_instr <= imem_rdata, id_pc <= pc, id_valid <= 1.
     - pc <= pc+4.
- Arithmetic:
  - All PC arithmetic is 32-bit unsigned, wrapping: 32'hFFFF_FFFC + 4 = 0.
  - id_pc_plus4 wraps the same way.
- Field outputs and id_jtarget are purely combinational from the IF/ID register. There is no decode latency beyond the register.
- Latency: an instruction at address A appears in IF/ID one edge after pc==A with no stall, flush or redirect.
- PC alignment:
  - pc[1:0] is always 2'b00.
  - A misaligned redirect is silently aligned; no exception is raised.
- Stall with a redirect in the same cycle: the redirect wins. The stalled IF/ID instruction is discarded, so the hazard unit must not assert redirect for an instruction it is stalling.
- Reset mid-stall or mid-redirect: state returns to the reset values on that edge, and the fetch at RESET_PC is visible in IF/ID one edge after reset deasserts.

Decomposition:
- Shared package mips_defs:
  - opcode/funct constants: R_TYPE, J, JAL, JR, ADDU, SUB, LUI, ORI, ADDI, ADDIU, BEQ, LW, SW;
  - RESET_PC default;
  - NOP_WORD;
  - field bit positions.
- One natural sub-module, if_id_reg: the 65-bit pipeline register (valid, pc, instr) with reset/flush/stall priority. The PC logic and field slicing stay in fetch_stage.

Test Plan:
- Reset, then release with imem returning 0x2008_0005 (addi $t0,$zero,5) at address 0:
  - pc 0 -> 4;
  - next cycle id_valid=1, id_pc=0, id_opcode=6'b001000, id_rt=8, id_imm16=16'h0005, id_pc_plus4=4.
- Run 3 cycles, then hold stall=1 for 2 cycles: pc frozen at 0xC; id_instr and id_pc unchanged; after release, pc resumes at 0x10.
- redirect_valid=1, redirect_pc=0x0000_0043, with stall=1 in the same cycle:
  - next pc=0x40, id_valid=0, id_instr=0;
  - following edge id_pc=0x40, id_valid=1.
- flush=1 with stall=0 at pc=0x20: pc=0x24, id_valid=0.
- flush=1 with stall=1 at pc=0x20: pc stays 0x20, id_valid=0.
- Redirect to 0xFFFF_FFFC, then one free cycle: pc wraps to 0; id_pc=0xFFFF_FFFC, id_pc_plus4=0.
- Fetch J word 0x0800_0010 at pc 0x0040_0000: id_jtarget=0x0000_0040.
- Assert reset during an active stall at pc=0x80: next edge pc=RESET_PC, id_valid=0, all fields 0.
